// File: rtl/pixel_sequencer.sv
// Frame sequencer for the pixel array: erase -> expose -> convert (with ADC ramp) -> read banks 1..4.
// Every output is a flop computed from the next state, so the array sees glitch-free Moore controls.
module pixel_sequencer #(
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 255,
  parameter int C_READ    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        cont_mode,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic [7:0]  ramp_data,
  output logic        read1,
  output logic        read2,
  output logic        read3,
  output logic        read4,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ1   = 3'd4,
    S_READ2   = 3'd5,
    S_READ3   = 3'd6,
    S_READ4   = 3'd7
  } state_t;

  // Phase lengths are 1..256, so the terminal-count load value always fits in 8 bits.
  localparam logic [7:0] LD_ERASE   = 8'(C_ERASE - 1);
  localparam logic [7:0] LD_EXPOSE  = 8'(C_EXPOSE - 1);
  localparam logic [7:0] LD_CONVERT = 8'(C_CONVERT - 1);
  localparam logic [7:0] LD_READ    = 8'(C_READ - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_end;

  logic        erase_q, erase_d;
  logic        expose_q, expose_d;
  logic        convert_q, convert_d;
  logic [7:0]  ramp_q, ramp_d;
  logic [3:0]  read_q, read_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  function automatic logic [7:0] load_value(input state_t s);
    logic [7:0] v;
    v = 8'd0;
    case (s)
      S_ERASE:   v = LD_ERASE;
      S_EXPOSE:  v = LD_EXPOSE;
      S_CONVERT: v = LD_CONVERT;
      S_READ1,
      S_READ2,
      S_READ3,
      S_READ4:   v = LD_READ;
      default:   v = 8'd0;
    endcase
    return v;
  endfunction

  assign phase_end = (cnt_q == 8'd0);

  // Next-state, phase counter and frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_ERASE;
        end
        S_READ4: begin
          if (phase_end) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = cont_mode ? S_ERASE : S_IDLE;
          end
        end
        default: begin
          if (phase_end) state_d = state_t'(state_q + 3'd1);
        end
      endcase
    end

    // Every phase change is a state change (READ4 -> ERASE included), so reload on any change.
    if (state_d != state_q) begin
      cnt_d = load_value(state_d);
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Registered controls decoded from the state being entered.
  always_comb begin
    erase_d   = (state_d == S_ERASE);
    expose_d  = (state_d == S_EXPOSE);
    convert_d = (state_d == S_CONVERT);
    busy_d    = (state_d != S_IDLE);
    ramp_d    = 8'd0;
    if (state_d == S_CONVERT && state_q == S_CONVERT) begin
      ramp_d = ramp_q + 8'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_read
    assign read_d[gi] = (state_d == state_t'(3'(S_READ1) + 3'(gi)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      ramp_q       <= 8'd0;
      read_q       <= 4'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      ramp_q       <= ramp_d;
      read_q       <= read_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign ramp_data  = ramp_q;
  assign read1      = read_q[0];
  assign read2      = read_q[1];
  assign read3      = read_q[2];
  assign read4      = read_q[3];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
